// File: rtl/iterative_alu.sv
// Iterative signed ALU: add/sub in one pass, mul/div/mod one bit per cycle.
// start/busy/done handshake; result and error code are registered at completion.
module iterative_alu #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     input1,
  input  logic [WIDTH-1:0]     input2,
  input  logic [3:0]           op_code,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   output1,
  output logic [1:0]           err_code,
  output logic [1:0]           dbg_state_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FINISH = 2'd2} state_t;

  // Handshake: a request is taken on a rising edge with start=1 and busy=0;
  // done pulses for one cycle when output1/err_code take their new values.
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [RW-1:0]     acc_q, mcand_q;
  logic [WIDTH-1:0]  work_q;   // mul: multiplier shifting out; div: dividend out, quotient in
  logic [WIDTH-1:0]  rem_q;

  logic [WIDTH-1:0]  abs_in1, abs_in2, mag_b;
  logic [WIDTH:0]    r_shift;
  logic [WIDTH-1:0]  r_sub, rem_d;
  logic              q_bit;
  logic [WIDTH:0]    sum, diff;
  logic              signs_differ;
  logic [RW-1:0]     quo_ext, rem_ext, res_d;
  logic [1:0]        err_d;

  assign dbg_state_o = state_q;

  always_comb begin
    abs_in1 = input1[WIDTH-1] ? -input1 : input1;
    abs_in2 = input2[WIDTH-1] ? -input2 : input2;
    mag_b   = b_q[WIDTH-1] ? -b_q : b_q;
    // Restoring step: bring in the next dividend bit, subtract if it fits.
    r_shift = {rem_q, work_q[WIDTH-1]};
    r_sub   = r_shift[WIDTH-1:0] - mag_b;
    q_bit   = (r_shift >= {1'b0, mag_b});
    rem_d   = q_bit ? r_sub : r_shift[WIDTH-1:0];
  end

  always_comb begin
    sum          = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    diff         = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    signs_differ = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    quo_ext      = {{WIDTH{1'b0}}, work_q};
    rem_ext      = {{WIDTH{1'b0}}, rem_q};
    res_d        = '0;
    err_d        = 2'b00;
    case (op_q)
      OP_ADD: begin
        res_d = {{(RW-WIDTH-1){sum[WIDTH]}}, sum};
        err_d = (sum[WIDTH] != sum[WIDTH-1]) ? 2'b01 : 2'b00;
      end
      OP_SUB: begin
        res_d = {{(RW-WIDTH-1){diff[WIDTH]}}, diff};
        err_d = (diff[WIDTH] != diff[WIDTH-1]) ? 2'b01 : 2'b00;
      end
      OP_MUL: res_d = signs_differ ? -acc_q : acc_q;
      OP_DIV: begin
        if (b_q == '0) begin
          err_d = 2'b10;
        end else begin
          res_d = signs_differ ? -quo_ext : quo_ext;
          // Only -2^(W-1) / -1 yields a positive quotient with the top bit set.
          err_d = (!signs_differ && work_q[WIDTH-1]) ? 2'b01 : 2'b00;
        end
      end
      OP_MOD: begin
        if (b_q == '0) err_d = 2'b10;
        else           res_d = a_q[WIDTH-1] ? -rem_ext : rem_ext;
      end
      default: err_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      output1  <= '0;
      err_code <= 2'b00;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      work_q   <= '0;
      rem_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op_code;
            a_q   <= input1;
            b_q   <= input2;
            cnt_q <= '0;
            busy  <= 1'b1;
            acc_q <= '0;
            rem_q <= '0;
            if (op_code == OP_MUL) begin
              mcand_q <= {{WIDTH{1'b0}}, abs_in1};
              work_q  <= abs_in2;
              state_q <= ITER;
            end else if ((op_code == OP_DIV || op_code == OP_MOD) && input2 != '0) begin
              work_q  <= abs_in1;
              state_q <= ITER;
            end else begin
              state_q <= FINISH;
            end
          end
        end
        ITER: begin
          if (op_q == OP_MUL) begin
            if (work_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            work_q  <= work_q >> 1;
          end else begin
            rem_q  <= rem_d;
            work_q <= {work_q[WIDTH-2:0], q_bit};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FINISH;
        end
        FINISH: begin
          output1  <= res_d;
          err_code <= err_d;
          done     <= 1'b1;
          busy     <= 1'b0;
          cnt_q    <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// Directed and randomized checks of iterative_alu against an integer-arithmetic model.
module tb_iterative_alu;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   input1, input2;
  logic [3:0]     op_code;
  logic           busy, done;
  logic [2*W-1:0] output1;
  logic [1:0]     err_code;
  logic [1:0]     dbg_state;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] last_res;

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .input1(input1), .input2(input2),
    .op_code(op_code), .busy(busy), .done(done), .output1(output1),
    .err_code(err_code), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic, {err, 32-bit result}.
  function automatic logic [33:0] model(input logic [3:0] op, input int a, input int b);
    longint r;
    logic [1:0] e;
    r = 0;
    e = 2'b00;
    case (op)
      4'd0: r = longint'(a) + longint'(b);
      4'd1: r = longint'(a) - longint'(b);
      4'd2: r = longint'(a) * longint'(b);
      4'd3: if (b == 0) e = 2'b10; else r = longint'(a) / longint'(b);
      4'd4: if (b == 0) e = 2'b10; else r = longint'(a) % longint'(b);
      default: e = 2'b11;
    endcase
    if ((op == 4'd0 || op == 4'd1 || op == 4'd3) && e == 2'b00 &&
        (r > longint'((1 << (W-1)) - 1) || r < -longint'(1 << (W-1))))
      e = 2'b01;
    return {e, r[31:0]};
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input int b);
    if (op == 4'd2 || ((op == 4'd3 || op == 4'd4) && b != 0)) return W + 1;
    return 1;
  endfunction

  // Called #1 after an edge; request is taken on the next edge.
  task automatic run_op(input string tag, input logic [3:0] op, input int a, input int b);
    logic [33:0] m;
    int lat;
    m = model(op, a, b);
    op_code = op;
    input1  = a[W-1:0];
    input2  = b[W-1:0];
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    input1  = W'($urandom);
    input2  = W'($urandom);
    op_code = 4'($urandom);
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_latency(op, b));
    check({tag, "_res"}, output1, m[31:0]);
    check({tag, "_err"}, err_code, m[33:32]);
    check({tag, "_idle"}, busy, 0);
    last_res = m[31:0];
  endtask

  initial begin
    int lat;
    logic seen_done;
    rst = 1'b1; start = 1'b0; input1 = '0; input2 = '0; op_code = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", output1, 0);
    check("rst_err", err_code, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    run_op("add_ovf", 4'd0, 32000, 16000);
    run_op("sub", 4'd1, 11, 15);
    run_op("mul", 4'd2, 11, 15);
    run_op("mul_neg", 4'd2, -3, 7);
    run_op("mul_min", 4'd2, -32768, -32768);
    run_op("div_neg", 4'd3, -7, 2);
    run_op("mod_neg", 4'd4, -7, 2);
    run_op("div_big", 4'd3, 32000, 16000);
    run_op("mod_big", 4'd4, 32000, 16000);
    run_op("div_zero", 4'd3, 11, 0);
    run_op("mod_zero", 4'd4, 11, 0);
    run_op("bad_op", 4'd7, 5, 6);
    run_op("div_min", 4'd3, -32768, -1);
    run_op("mod_min", 4'd4, -32768, -1);
    run_op("sub_ovf", 4'd1, -32768, 1);

    // done must drop after a single cycle when nothing new is requested
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("hold_out", output1, last_res);

    // A second start during the operation is ignored
    op_code = 4'd2; input1 = 16'd11; input2 = 16'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ign_hold_out", output1, last_res);
    op_code = 4'd2; input1 = 16'd2; input2 = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign_lat", lat, W + 1);
    check("ign_res", output1, 165);
    check("ign_err", err_code, 0);
    // Start in the done cycle: accepted immediately
    run_op("b2b", 4'd3, -100, 7);

    // Abort by reset mid-operation
    op_code = 4'd2; input1 = 16'd11; input2 = 16'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", output1, 0);
    check("abort_err", err_code, 0);
    check("abort_state", dbg_state, 0);
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_op("after_abort", 4'd2, 11, 15);

    // Randomized operations, back to back
    for (int i = 0; i < 60; i++) begin
      int a, b;
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      a  = int'($urandom_range(0, 65535)) - 32768;
      b  = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 4)) - 2;
      if ($urandom_range(0, 7) == 0) a = -32768;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
